// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
// Holds the arbiter state encoding and the read byte-mask constant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

  // Wide enough for any practical data width; the top slices off DATA_W/8 bits.
  localparam logic [127:0] BMASK_ALL_ONES = '1;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Transaction watchdog: counts cycles a memory request waits without an ack
// and flags expiry on the cycle the count would reach TIMEOUT_CYC.
module arb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Expire on the TIMEOUT_CYC-th waiting cycle so the request is dropped at that edge.
  assign expire = en && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port variable-latency memory between instruction fetch
// and load/store, one registered transaction at a time, with stall outputs.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_valid,
  output logic [DATA_W-1:0]   o_if_instr,
  input  logic                i_flush,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_bmask,
  output logic                o_d_valid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_if_stall,
  output logic                o_mem_stall,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic                i_mem_ack,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_err
);

  localparam int BM_W = DATA_W / 8;
  localparam logic [BM_W-1:0] BMASK_RD = BMASK_ALL_ONES[BM_W-1:0];

  arb_state_e state;
  arb_state_e next_state;
  logic       grant_data;
  logic       grant_fetch;
  logic       grant;
  logic       drop;
  logic       wait_ack;
  logic       expire;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Data side wins in IDLE: the MEM-stage instruction is older than the fetch.
  always_comb begin
    next_state  = state;
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (i_d_req) begin
          next_state = ARB_DATA;
          grant_data = 1'b1;
        end else if (i_if_req && !i_flush) begin
          next_state  = ARB_FETCH;
          grant_fetch = 1'b1;
        end
      end
      ARB_FETCH, ARB_DATA: begin
        if (i_mem_ack || expire) begin
          next_state = ARB_IDLE;
        end
      end
      default: next_state = ARB_IDLE;
    endcase
  end

  assign grant    = grant_data | grant_fetch;
  assign wait_ack = o_mem_req & ~i_mem_ack;

  arb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (grant),
    .en     (wait_ack),
    .expire (expire)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_bmask <= '0;
    end else if (grant_data) begin
      o_mem_req   <= 1'b1;
      o_mem_we    <= i_d_we;
      o_mem_addr  <= i_d_addr;
      o_mem_wdata <= i_d_wdata;
      o_mem_bmask <= i_d_we ? i_d_bmask : BMASK_RD;
    end else if (grant_fetch) begin
      o_mem_req   <= 1'b1;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= i_if_addr;
      o_mem_wdata <= '0;
      o_mem_bmask <= BMASK_RD;
    end else if (i_mem_ack || expire) begin
      o_mem_req <= 1'b0;
    end
  end

  // A redirect during a fetch lets the memory finish but discards the returned word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      drop <= 1'b0;
    end else if (state == ARB_FETCH) begin
      if (next_state != ARB_FETCH) begin
        drop <= 1'b0;
      end else if (i_flush) begin
        drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else if (expire) begin
      o_err <= 1'b1;
    end
  end

  assign o_if_valid  = (state == ARB_FETCH) & i_mem_ack & ~drop & ~i_flush;
  assign o_d_valid   = (state == ARB_DATA) & i_mem_ack;
  assign o_if_instr  = i_mem_rdata;
  assign o_d_rdata   = i_mem_rdata;
  assign o_if_stall  = i_if_req & ~o_if_valid;
  assign o_mem_stall = i_d_req & ~o_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for priority, flush, timeout, stray ack and mid-transaction reset.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_bmask;
  logic        if_valid;
  logic [31:0] if_instr;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        if_stall;
  logic        mem_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic        model_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] model_rdata = 32'h0;
  logic        err;

  int mem_lat = 2;
  bit never_ack = 1'b0;
  int mcnt = 0;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int if_pulses = 0;
  int d_pulses = 0;
  bit req_prev = 1'b0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
  } req_t;

  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    int          lat;
  } vec_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  vec_t        vecs[8];

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_valid(if_valid), .o_if_instr(if_instr),
    .i_flush(flush),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .i_d_bmask(d_bmask),
    .o_d_valid(d_valid), .o_d_rdata(d_rdata),
    .o_if_stall(if_stall), .o_mem_stall(mem_stall),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .i_mem_ack(model_ack | stray_ack), .i_mem_rdata(model_rdata),
    .o_err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: ack in the mem_lat-th cycle of a request, never if never_ack.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !mem_req) begin
        mcnt = 0;
        model_ack = 1'b0;
        model_rdata = 32'h0;
      end else begin
        mcnt++;
        model_ack = !never_ack && (mcnt == mem_lat);
        model_rdata = model_ack ? mem_word(mem_addr) : 32'h0;
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin : mon
    req_t e;
    if (rst_n) begin
      if (mem_req) req_cycles++;
      if (mem_req && !req_prev) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: addr 0x%0h, none expected", mem_addr);
        end else begin
          e = exp_req_q.pop_front();
          check("grant_we", 64'(mem_we), 64'(e.we));
          check("grant_addr", 64'(mem_addr), 64'(e.addr));
          check("grant_wdata", 64'(mem_wdata), 64'(e.wdata));
          check("grant_bmask", 64'(mem_bmask), 64'(e.bmask));
        end
      end
      if (if_valid) begin
        if_pulses++;
        if (exp_if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_if_valid: instr 0x%0h, none expected", if_instr);
        end else check("if_instr", 64'(if_instr), 64'(exp_if_q.pop_front()));
      end
      if (d_valid) begin
        d_pulses++;
        if (exp_d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_d_valid: rdata 0x%0h, none expected", d_rdata);
        end else check("d_rdata", 64'(d_rdata), 64'(exp_d_q.pop_front()));
      end
    end
    req_prev = mem_req;
  end

  task automatic wait_valid(input bit is_fetch, output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = is_fetch ? if_valid : d_valid;
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] bm);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.bmask = bm;
    exp_req_q.push_back(r);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int rc0, ip0, dp0;
    bit got;
    rc0 = req_cycles; ip0 = if_pulses; dp0 = d_pulses;
    mem_lat = v.lat;
    if (v.is_fetch) begin
      push_req(1'b0, v.addr, 32'h0, 4'hF);
      exp_if_q.push_back(mem_word(v.addr));
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      push_req(v.we, v.addr, v.wdata, v.we ? v.bmask : 4'hF);
      exp_d_q.push_back(mem_word(v.addr));
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_bmask = v.bmask;
    end
    wait_valid(v.is_fetch, got);
    check($sformatf("v%0d_valid_seen", idx), 64'(got), 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_req_cycles", idx), 64'(req_cycles - rc0), 64'(v.lat));
    check($sformatf("v%0d_if_pulses", idx), 64'(if_pulses - ip0), v.is_fetch ? 64'd1 : 64'd0);
    check($sformatf("v%0d_d_pulses", idx), 64'(d_pulses - dp0), v.is_fetch ? 64'd0 : 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, ok;
    int rc0, ip0, dp0, cnt;
    bit seen, done;

    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_bmask = 4'h0;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          4'h0, 3};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF,  4'b0011, 2};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_2008, 32'h0,          4'h0, 2};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,          4'h0, 2};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_3FFC, 32'h0,          4'h0, 5};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_1000, 32'hCAFE_F00D,  4'b1111, 4};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0108, 32'h0,          4'h0, TO};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_2010, 32'h1234_5678,  4'b1000, 7};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_bmask", 64'(mem_bmask), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_d_valid", 64'(d_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    check("err_after_table", 64'(err), 64'd0);

    // Simultaneous fetch and load: data first, fetch stalled until its own completion.
    mem_lat = 3;
    push_req(1'b0, 32'h2000, 32'h0, 4'hF);
    push_req(1'b0, 32'h300, 32'h0, 4'hF);
    exp_d_q.push_back(mem_word(32'h2000));
    exp_if_q.push_back(mem_word(32'h300));
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'h0; d_bmask = 4'h0;
    got = 1'b0; ok = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_stall !== 1'b1) ok = 1'b0;
      if (d_valid) begin
        got = 1'b1;
        if (mem_stall !== 1'b0) ok = 1'b0;
      end else if (mem_stall !== 1'b1) ok = 1'b0;
    end
    check("t2_data_done", 64'(got), 64'd1);
    check("t2_stalls_during_data", 64'(ok), 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    got = 1'b0; ok = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (if_valid) begin
        got = 1'b1;
        check("t2_if_stall_on_valid", 64'(if_stall), 64'd0);
      end else if (if_stall !== 1'b1) ok = 1'b0;
    end
    check("t2_fetch_done", 64'(got), 64'd1);
    check("t2_if_stall_held", 64'(ok), 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;

    // Flush: blocks the IDLE grant, then kills an in-flight fetch; redirected fetch follows.
    mem_lat = 4;
    rc0 = req_cycles; ip0 = if_pulses;
    push_req(1'b0, 32'h400, 32'h0, 4'hF);
    push_req(1'b0, 32'h500, 32'h0, 4'hF);
    exp_if_q.push_back(mem_word(32'h500));
    if_req = 1'b1; if_addr = 32'h400; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("t4_no_grant_on_flush", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    flush = 1'b1; if_addr = 32'h500;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_valid(1'b1, got);
    check("t4_refetch_valid", 64'(got), 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    check("t4_if_pulses", 64'(if_pulses - ip0), 64'd1);
    check("t4_req_cycles", 64'(req_cycles - rc0), 64'd8);

    // Timeout: memory never acks.
    never_ack = 1'b1;
    dp0 = d_pulses;
    push_req(1'b0, 32'h3000, 32'h0, 4'hF);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    cnt = 0; seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (mem_req) begin
        seen = 1'b1; cnt++;
      end else if (seen) begin
        done = 1'b1;
        d_req = 1'b0;
      end
    end
    d_req = 1'b0;
    check("t5_aborted", 64'(done), 64'd1);
    check("t5_req_cycles", 64'(cnt), 64'(TO));
    check("t5_err_set", 64'(err), 64'd1);
    check("t5_no_d_valid", 64'(d_pulses - dp0), 64'd0);
    never_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_idle_no_req", 64'(mem_req), 64'd0);
    run_vec('{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 2}, 8);
    check("t5_err_sticky", 64'(err), 64'd1);

    // Ack while idle must be ignored.
    @(posedge clk); #1;
    stray_ack = 1'b1;
    @(negedge clk);
    check("stray_if_valid", 64'(if_valid), 64'd0);
    check("stray_d_valid", 64'(d_valid), 64'd0);
    @(posedge clk); #1;
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_no_req", 64'(mem_req), 64'd0);

    // Reset in the middle of a store.
    mem_lat = 6;
    ip0 = if_pulses; dp0 = d_pulses;
    push_req(1'b1, 32'h5000, 32'hA5A5_A5A5, 4'b0101);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000; d_wdata = 32'hA5A5_A5A5; d_bmask = 4'b0101;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_mem_req", 64'(mem_req), 64'd0);
    check("t6_mem_we", 64'(mem_we), 64'd0);
    check("t6_mem_addr", 64'(mem_addr), 64'd0);
    check("t6_err_cleared", 64'(err), 64'd0);
    check("t6_d_valid", 64'(d_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_no_pulses", 64'(if_pulses - ip0 + d_pulses - dp0), 64'd0);
    run_vec('{1'b0, 1'b0, 32'h0000_2020, 32'h0, 4'h0, 2}, 9);

    check("exp_req_q_empty", 64'(exp_req_q.size()), 64'd0);
    check("exp_if_q_empty", 64'(exp_if_q.size()), 64'd0);
    check("exp_d_q_empty", 64'(exp_d_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
